// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants for the 3-digit 7-segment scan driver: segment patterns
// (active-high, {g,f,e,d,c,b,a}) and digit index encodings.
package seg7_scan_driver_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    DIG_ONES = 2'd0,
    DIG_TENS = 2'd1,
    DIG_HUND = 2'd2
  } dig_idx_e;

  // One-hot digit enable (active-high) for a given digit index.
  function automatic logic [2:0] dig_onehot(input dig_idx_e idx);
    logic [2:0] oh;
    case (idx)
      DIG_ONES: oh = 3'b001;
      DIG_TENS: oh = 3'b010;
      DIG_HUND: oh = 3'b100;
      default:  oh = 3'b001;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_digit_dec.sv
// Combinational BCD nibble to 7-segment decoder; nibbles A-F show "E",
// blank forces all segments off.
module seg7_digit_dec
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_BLANK;
    if (!blank) begin
      case (nibble)
        4'd0:    pattern = SEG_0;
        4'd1:    pattern = SEG_1;
        4'd2:    pattern = SEG_2;
        4'd3:    pattern = SEG_3;
        4'd4:    pattern = SEG_4;
        4'd5:    pattern = SEG_5;
        4'd6:    pattern = SEG_6;
        4'd7:    pattern = SEG_7;
        4'd8:    pattern = SEG_8;
        4'd9:    pattern = SEG_9;
        default: pattern = SEG_E;
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Latches a 3-digit BCD result and time-multiplexes it onto a common-segment
// 7-segment display with leading-zero blanking and configurable polarities.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter logic [15:0] SCAN_DIV    = 16'd50000,
  parameter logic        SEG_ACT_LOW = 1'b0,
  parameter logic        DIG_ACT_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] bcd_in,
  input  logic        load,
  input  logic        lzb,
  output logic [6:0]  seg,
  output logic [2:0]  dig,
  output logic        frame
);

  localparam logic [6:0] SEG_IDLE = {7{SEG_ACT_LOW}};
  localparam logic [2:0] DIG_IDLE = {3{DIG_ACT_LOW}};

  logic [15:0] presc;
  logic        tick;
  logic [11:0] bcd_reg;
  dig_idx_e    idx, idx_nxt;
  logic [3:0]  nib_sel;
  logic        blank_sel;
  logic [6:0]  pat;

  assign tick = (presc == SCAN_DIV - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= 16'd0;
    end else if (tick) begin
      presc <= 16'd0;
    end else begin
      presc <= presc + 16'd1;
    end
  end

  // Digit index state: advances once per slot, ones -> tens -> hundreds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= DIG_ONES;
    end else begin
      idx <= idx_nxt;
    end
  end

  always_comb begin
    idx_nxt = idx;
    if (tick) begin
      case (idx)
        DIG_ONES: idx_nxt = DIG_TENS;
        DIG_TENS: idx_nxt = DIG_HUND;
        DIG_HUND: idx_nxt = DIG_ONES;
        default:  idx_nxt = DIG_ONES;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_reg <= 12'h000;
    end else if (load) begin
      bcd_reg <= bcd_in;
    end
  end

  // Select the digit about to be shown; an invalid nibble never counts as zero.
  always_comb begin
    nib_sel   = bcd_reg[3:0];
    blank_sel = 1'b0;
    case (idx_nxt)
      DIG_TENS: begin
        nib_sel   = bcd_reg[7:4];
        blank_sel = lzb && (bcd_reg[11:8] == 4'd0) && (bcd_reg[7:4] == 4'd0);
      end
      DIG_HUND: begin
        nib_sel   = bcd_reg[11:8];
        blank_sel = lzb && (bcd_reg[11:8] == 4'd0);
      end
      default: begin
        nib_sel   = bcd_reg[3:0];
        blank_sel = 1'b0;
      end
    endcase
  end

  seg7_digit_dec u_dec (
    .nibble  (nib_sel),
    .blank   (blank_sel),
    .pattern (pat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg   <= SEG_IDLE;
      dig   <= DIG_IDLE;
      frame <= 1'b0;
    end else if (tick) begin
      seg   <= pat ^ SEG_IDLE;
      dig   <= dig_onehot(idx_nxt) ^ DIG_IDLE;
      frame <= (idx == DIG_HUND);
    end else begin
      frame <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two instances (active-high, SCAN_DIV=4 and
// active-low, SCAN_DIV=5) checked every cycle against a slot-count model.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n0 = 1'b0;
  logic        rst_n1 = 1'b0;
  logic [11:0] bcd_in = 12'h000;
  logic        load = 1'b0;
  logic        lzb = 1'b0;
  logic [6:0]  seg0, seg1;
  logic [2:0]  dig0, dig1;
  logic        frame0, frame1;

  int checks = 0;
  int passes = 0;
  bit cmp_en = 1'b0;

  // clock / reset block
  always #5 clk = ~clk;

  seg7_scan_driver #(.SCAN_DIV(16'd4), .SEG_ACT_LOW(1'b0), .DIG_ACT_LOW(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n0), .bcd_in(bcd_in), .load(load), .lzb(lzb),
    .seg(seg0), .dig(dig0), .frame(frame0)
  );

  seg7_scan_driver #(.SCAN_DIV(16'd5), .SEG_ACT_LOW(1'b1), .DIG_ACT_LOW(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n1), .bcd_in(bcd_in), .load(load), .lzb(lzb),
    .seg(seg1), .dig(dig1), .frame(frame1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Pattern the display must show for digit i (0=ones,1=tens,2=hundreds).
  function automatic logic [6:0] exp_pat(input logic [11:0] b, input int i, input logic lz);
    logic [3:0] h, t, o, n;
    bit blank;
    h = b[11:8]; t = b[7:4]; o = b[3:0];
    n = (i == 0) ? o : (i == 1) ? t : h;
    blank = (i == 2 && lz && h == 4'd0) || (i == 1 && lz && h == 4'd0 && t == 4'd0);
    if (blank) return 7'h00;
    case (n)
      4'd0: return 7'h3F; 4'd1: return 7'h06; 4'd2: return 7'h5B; 4'd3: return 7'h4F;
      4'd4: return 7'h66; 4'd5: return 7'h6D; 4'd6: return 7'h7D; 4'd7: return 7'h07;
      4'd8: return 7'h7F; 4'd9: return 7'h6F;
      default: return 7'h79;
    endcase
  endfunction

  // Model: k = clock edges since reset release; a display update happens
  // every DIV edges, showing digit (updates mod 3) from the value held before the edge.
  int k0 = 0, k1 = 0;
  logic [11:0] mb0 = 12'h000, mb1 = 12'h000;
  logic [6:0]  es0 = 7'h00, es1 = 7'h7F;
  logic [2:0]  ed0 = 3'b000, ed1 = 3'b111;
  logic        ef0 = 1'b0, ef1 = 1'b0;

  always @(posedge clk or negedge rst_n0) begin
    if (!rst_n0) begin
      k0 = 0; mb0 = 12'h000; es0 = 7'h00; ed0 = 3'b000; ef0 = 1'b0;
    end else begin
      int i;
      k0++;
      ef0 = 1'b0;
      if (k0 % 4 == 0) begin
        i = (k0 / 4) % 3;
        es0 = exp_pat(mb0, i, lzb);
        ed0 = 3'(1 << i);
        ef0 = (i == 0);
      end
      if (load) mb0 = bcd_in;
    end
  end

  always @(posedge clk or negedge rst_n1) begin
    if (!rst_n1) begin
      k1 = 0; mb1 = 12'h000; es1 = 7'h7F; ed1 = 3'b111; ef1 = 1'b0;
    end else begin
      int i;
      k1++;
      ef1 = 1'b0;
      if (k1 % 5 == 0) begin
        i = (k1 / 5) % 3;
        es1 = ~exp_pat(mb1, i, lzb);
        ed1 = ~3'(1 << i);
        ef1 = (i == 0);
      end
      if (load) mb1 = bcd_in;
    end
  end

  // Scoreboard: compare both instances every cycle, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("seg0", 32'(seg0), 32'(es0));
      chk("dig0", 32'(dig0), 32'(ed0));
      chk("frame0", 32'(frame0), 32'(ef0));
      chk("seg1", 32'(seg1), 32'(es1));
      chk("dig1", 32'(dig1), 32'(ed1));
      chk("frame1", 32'(frame1), 32'(ef1));
    end
  end

  // Driver tasks
  task automatic to_tick0();
    int g = 0;
    @(negedge clk);
    while (k0 % 4 != 0 && g < 10) begin
      @(negedge clk);
      g++;
    end
    if (g >= 10) chk("tick0_timeout", 32'd1, 32'd0);
  endtask

  task automatic load_val(input logic [11:0] v);
    bcd_in = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic collect3(output logic [6:0] h, output logic [6:0] t, output logic [6:0] o);
    h = 7'h55; t = 7'h55; o = 7'h55;
    for (int n = 0; n < 3; n++) begin
      to_tick0();
      case (dig0)
        3'b100: h = seg0;
        3'b010: t = seg0;
        3'b001: o = seg0;
        default: chk("dig0_onehot", 32'(dig0), 32'd1);
      endcase
    end
  endtask

  initial begin
    logic [6:0] h, t, o;
    int g;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    repeat (8) @(negedge clk);
    rst_n0 = 1'b1;
    rst_n1 = 1'b1;

    // Reset state, then first update on the 4th edge shows tens of 0.
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      chk("rst_seg", 32'(seg0), 32'h00);
      chk("rst_dig", 32'(dig0), 32'h0);
      chk("rst_frame", 32'(frame0), 32'h0);
    end
    @(negedge clk);
    chk("first_dig", 32'(dig0), 32'h2);
    chk("first_seg", 32'(seg0), 32'h3F);

    // Full display of 123.
    load_val(12'h123);
    to_tick0();
    chk("f123_h_dig", 32'(dig0), 32'h4);
    chk("f123_h_seg", 32'(seg0), 32'h06);
    to_tick0();
    chk("f123_o_dig", 32'(dig0), 32'h1);
    chk("f123_o_seg", 32'(seg0), 32'h4F);
    chk("f123_frame", 32'(frame0), 32'h1);
    to_tick0();
    chk("f123_t_dig", 32'(dig0), 32'h2);
    chk("f123_t_seg", 32'(seg0), 32'h5B);

    // Leading-zero blanking and invalid digit.
    lzb = 1'b1;
    load_val(12'h007);
    collect3(h, t, o);
    chk("lz007_h", 32'(h), 32'h00);
    chk("lz007_t", 32'(t), 32'h00);
    chk("lz007_o", 32'(o), 32'h07);
    load_val(12'h070);
    collect3(h, t, o);
    chk("lz070_h", 32'(h), 32'h00);
    chk("lz070_t", 32'(t), 32'h07);
    chk("lz070_o", 32'(o), 32'h3F);
    load_val(12'h0A5);
    collect3(h, t, o);
    chk("inv_h", 32'(h), 32'h00);
    chk("inv_t", 32'(t), 32'h79);
    chk("inv_o", 32'(o), 32'h6D);

    // Load coinciding with a tick uses the old value for that update.
    lzb = 1'b0;
    load_val(12'h111);
    collect3(h, t, o);
    g = 0;
    while (k0 % 4 != 3 && g < 10) begin
      @(negedge clk);
      g++;
    end
    load_val(12'h999);
    chk("coinc_old", 32'(seg0), 32'h06);
    for (int n = 0; n < 3; n++) begin
      to_tick0();
      chk("coinc_new", 32'(seg0), 32'h6F);
    end

    // Async reset mid-scan on the active-low instance.
    chk("pre_rst_dig1_active", 32'(dig1 != 3'b111), 32'd1);
    @(negedge clk);
    #2 rst_n1 = 1'b0;
    #1;
    chk("arst_seg1", 32'(seg1), 32'h7F);
    chk("arst_dig1", 32'(dig1), 32'h7);
    chk("arst_frame1", 32'(frame1), 32'h0);
    repeat (3) @(negedge clk);
    rst_n1 = 1'b1;
    g = 0;
    while (k1 < 5 && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("arst_first_seg1", 32'(seg1), 32'h40);
    chk("arst_first_dig1", 32'(dig1), 32'h5);

    // Randomized phase; the scoreboard checks every cycle.
    for (int n = 0; n < 1500; n++) begin
      logic [11:0] v;
      for (int d = 0; d < 3; d++)
        v[d*4 +: 4] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      bcd_in = v;
      load = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 40) == 0) lzb = ~lzb;
      @(negedge clk);
    end
    load = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream display stage for the calculator datapath. Consumes the 12-bit BCD result (3 digits) from the binary-to-BCD decoder.
- Latches the result on a load strobe and time-multiplexes it onto a 3-digit common-segment 7-segment display.
- Provides leading-zero blanking and invalid-digit indication ("E").

Parameters:
- SCAN_DIV, 16'd50000, clock cycles per digit slot; legal range 2..65535.
- SEG_ACT_LOW, 1'b0, 1 = segment outputs active-low.
- DIG_ACT_LOW, 1'b0, 1 = digit enables active-low.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- bcd_in  input  12  BCD value {hundreds[11:8], tens[7:4], ones[3:0]}.
- load  input  1  when high, bcd_in is captured at this clk edge.
- lzb  input  1  leading-zero blanking enable; level, sampled every cycle.
- seg  output  7  segment pattern {g,f,e,d,c,b,a}, registered.
- dig  output  3  digit enable, one-hot; dig[0]=ones, dig[1]=tens, dig[2]=hundreds; registered.
- frame  output  1  one-cycle pulse on each tick where the digit index wraps from 2 to 0.

Behaviour:
- Reset (async assert, sync release):
  - Prescaler = 0, digit index = 0, bcd_reg = 12'h000.
  - seg and dig drive the inactive level: all 0 if not ACT_LOW, all 1 if ACT_LOW.
  - frame = 0.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - tick = (prescaler == SCAN_DIV-1), asserted for exactly 1 cycle per slot.
- Digit index:
  - On tick, advances 0->1->2->0.
  - On the tick where the index goes 2->0, frame = 1 for that cycle, registered with seg/dig.
- Output registers:
  - Load only on tick cycles, otherwise hold.
  - On tick, dig gets the one-hot value for the NEXT index.
  - On tick, seg gets the pattern of that digit, taken from the bcd_reg value present in that cycle.
  - First display update is at the first tick after reset, SCAN_DIV cycles after reset release, and shows index 1 (tens).
- Capture:
  - When load = 1, bcd_reg <= bcd_in.
  - The new value becomes visible on each digit at that digit's next tick. There is no mid-slot update.
  - load coinciding with tick: the tick uses the OLD bcd_reg and the new value applies from the following tick.
- Decode, active-high before polarity inversion:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Nibble A-F: 79 ("E").
  - Blank: 00.
- Blanking with lzb = 1:
  - Hundreds blank if its nibble == 0.
  - Tens blank if hundreds == 0 and tens == 0.
  - Ones are never blanked.
  - An invalid nibble is never treated as zero.
- Blanking with lzb = 0: all digits are shown.
- Blanked digit: dig is still driven active, seg is all inactive.
- Polarity: seg is bitwise-inverted when SEG_ACT_LOW = 1; dig is inverted when DIG_ACT_LOW = 1.
- Exactly one dig bit is active at any time after the first tick.
- rst_n asserted mid-scan: immediate return to the reset state, independent of clk.

Decomposition:
- Shared package holds:
  - the 7-bit segment constants SEG_0..SEG_9, SEG_E, SEG_BLANK;
  - digit index encodings DIG_ONES = 0, DIG_TENS = 1, DIG_HUND = 2.
- One combinational sub-module, seg7_digit_dec:
  - inputs: 4-bit nibble, blank flag;
  - output: 7-bit active-high pattern.
- The top module instantiates seg7_digit_dec once, on the muxed nibble of the next index.

Test Plan:
- Reset check (SCAN_DIV=4, all polarity params 0): hold rst_n low for 10 cycles, release -> seg=0, dig=0, frame=0 for 3 cycles. On cycle 4 after release: dig=3'b010, seg=7'h3F (tens of 0, lzb=0).
- Full display: load 12'h123, lzb=0, observe 3 ticks -> (dig=010, seg=5B), (dig=100, seg=06), (dig=001, seg=4F). frame pulses with the dig=001 update.
- Leading-zero blanking: load 12'h007, lzb=1 -> hundreds and tens slots give seg=00 with dig active; ones slot gives seg=07. Load 12'h070 -> tens=07, ones=3F, hundreds=00.
- Invalid digit: load 12'h0A5, lzb=1 -> hundreds=00, tens=79 (not blanked), ones=6D.
- Load coinciding with tick: bcd_reg=12'h111, pulse load with 12'h999 on a tick cycle -> that update shows 06; all subsequent slots show 6F.
- Async reset mid-scan with SEG_ACT_LOW=1, DIG_ACT_LOW=1: drop rst_n between edges while dig is active -> seg=7'h7F and dig=3'b111 immediately, bcd_reg cleared. After release, the first tick shows the tens digit with seg = ~3F = 7'h40.
